// File: rtl/alu_result_accumulator_pkg.sv
// Shared definitions for the ALU result accumulator: FSM state encoding and default widths.
package alu_result_accumulator_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ACC_W  = 8;
  localparam int DEF_COUNT  = 4;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/alu_result_accumulator_acc_add_ovf.sv
// Combinational two's-complement adder at accumulator width, flagging signed overflow.
module acc_add_ovf #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  logic [ACC_W-1:0] w_sum;

  assign w_sum = i_a + i_b;
  assign o_sum = w_sum;
  // Overflow only when both operands share a sign and the result's sign differs.
  assign o_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_sum[ACC_W-1] != i_a[ACC_W-1]);

endmodule

// File: rtl/alu_result_accumulator.sv
// Sums COUNT signed results into a wrap-around accumulator with a sticky overflow flag,
// handing each finished batch downstream over a valid/ready handshake.
module alu_result_accumulator
  import alu_result_accumulator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int COUNT  = DEF_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_q_in,
  input  logic              i_ovf_in,
  input  logic              i_clear,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_acc_out,
  output logic              o_sticky_ovf,
  output logic [CNT_W-1:0]  o_batch_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_transfer;
  logic [ACC_W-1:0] w_q_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf;

  assign w_accept   = i_in_valid && (r_state == ST_ACCUM);
  assign w_transfer = i_out_ready && (r_state == ST_DONE);
  assign w_q_ext    = {{(ACC_W-DATA_W){i_q_in[DATA_W-1]}}, i_q_in};

  acc_add_ovf #(
    .ACC_W(ACC_W)
  ) u_add (
    .i_a  (r_acc),
    .i_b  (w_q_ext),
    .o_sum(w_sum),
    .o_ovf(w_add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // clear overrides everything, including a transfer or the last accept of a batch.
  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_accept && (r_cnt == LAST_IDX)) w_state_next = ST_DONE;
        ST_DONE:  if (w_transfer) w_state_next = ST_ACCUM;
        default:  w_state_next = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (i_clear || w_transfer) begin
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_acc    <= w_sum;
      r_sticky <= r_sticky | i_ovf_in | w_add_ovf;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign o_in_ready   = (r_state == ST_ACCUM);
  assign o_out_valid  = (r_state == ST_DONE);
  assign o_acc_out    = r_acc;
  assign o_sticky_ovf = r_sticky;
  assign o_batch_cnt  = r_cnt;

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Scoreboard bench: two accumulators (8-bit and 5-bit) share stimulus; a behavioural model
// predicts batch results, a monitor pops and compares on each output transfer.
module tb_alu_result_accumulator;

  localparam int COUNT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] q_in = '0;
  logic       ovf_in = 1'b0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready8, out_valid8, sticky8;
  logic [7:0] acc8, cnt8;
  logic       in_ready5, out_valid5, sticky5;
  logic [4:0] acc5;
  logic [7:0] cnt5;

  int n_vec = 0;
  int n_err = 0;
  int n_xfer = 0;

  // Behavioural model state
  bit  m_done = 0;
  int  m_cnt = 0;
  int  m_acc8 = 0, m_acc5 = 0;
  bit  m_stk8 = 0, m_stk5 = 0;
  int  exp_acc8[$], exp_acc5[$];
  bit  exp_stk8[$], exp_stk5[$];

  always #5 clk = ~clk;

  alu_result_accumulator #(.DATA_W(4), .ACC_W(8), .COUNT(COUNT)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready8),
    .i_q_in(q_in), .i_ovf_in(ovf_in), .i_clear(clear), .o_out_valid(out_valid8),
    .i_out_ready(out_ready), .o_acc_out(acc8), .o_sticky_ovf(sticky8), .o_batch_cnt(cnt8)
  );

  alu_result_accumulator #(.DATA_W(4), .ACC_W(5), .COUNT(COUNT)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready5),
    .i_q_in(q_in), .i_ovf_in(ovf_in), .i_clear(clear), .o_out_valid(out_valid5),
    .i_out_ready(out_ready), .o_acc_out(acc5), .o_sticky_ovf(sticky5), .o_batch_cnt(cnt5)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Signed add at width w using plain integer range checks, wrapping modulo 2^w.
  function automatic void add_step(input int w, input int q, input bit ov,
                                   inout int acc, inout bit stk);
    int lim, s;
    bit o;
    lim = 1 << (w - 1);
    s = acc + q;
    o = (s >= lim) || (s < -lim);
    if (s >= lim) s -= 2 * lim;
    else if (s < -lim) s += 2 * lim;
    acc = s;
    stk = stk | ov | o;
  endfunction

  task automatic model_clr();
    m_done = 0; m_cnt = 0;
    m_acc8 = 0; m_acc5 = 0;
    m_stk8 = 0; m_stk5 = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clr();
        exp_acc8.delete(); exp_acc5.delete();
        exp_stk8.delete(); exp_stk5.delete();
      end else if (clear) begin
        if (m_done) begin
          void'(exp_acc8.pop_back()); void'(exp_acc5.pop_back());
          void'(exp_stk8.pop_back()); void'(exp_stk5.pop_back());
        end
        model_clr();
      end else if (m_done) begin
        if (out_ready) model_clr();
      end else if (in_valid) begin
        add_step(8, int'($signed(q_in)), ovf_in, m_acc8, m_stk8);
        add_step(5, int'($signed(q_in)), ovf_in, m_acc5, m_stk5);
        m_cnt++;
        if (m_cnt == COUNT) begin
          m_done = 1;
          exp_acc8.push_back(m_acc8); exp_stk8.push_back(m_stk8);
          exp_acc5.push_back(m_acc5); exp_stk5.push_back(m_stk5);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", int'(in_ready8), int'(!m_done));
        chk("out_valid", int'(out_valid8), int'(m_done));
        chk("out_valid5", int'(out_valid5), int'(m_done));
        chk("batch_cnt", int'(cnt8), m_cnt);
        chk("acc8_live", int'($signed(acc8)), m_acc8);
        chk("acc5_live", int'($signed(acc5)), m_acc5);
        chk("sticky8_live", int'(sticky8), int'(m_stk8));
        chk("sticky5_live", int'(sticky5), int'(m_stk5));
        if (out_valid8 && out_ready && !clear) begin
          if (exp_acc8.size() == 0 || exp_acc5.size() == 0) begin
            chk("xfer_unexpected", 1, 0);
          end else begin
            chk("xfer_acc8", int'($signed(acc8)), exp_acc8.pop_front());
            chk("xfer_stk8", int'(sticky8), int'(exp_stk8.pop_front()));
            chk("xfer_acc5", int'($signed(acc5)), exp_acc5.pop_front());
            chk("xfer_stk5", int'(sticky5), int'(exp_stk5.pop_front()));
            n_xfer++;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int q, input bit ov);
    in_valid = 1'b1;
    q_in = 4'(q);
    ovf_in = ov;
    cyc();
    in_valid = 1'b0;
    ovf_in = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Reset mid-batch
    feed(3, 0); feed(5, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_acc", int'(acc8), 0);
    chk("rst_cnt", int'(cnt8), 0);
    chk("rst_out_valid", int'(out_valid8), 0);
    chk("rst_in_ready", int'(in_ready8), 1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Plain batch, then hold DONE against backpressure with in_valid high
    feed(3, 0); feed(-2, 0); feed(-7, 0); feed(2, 0);
    chk("done_valid", int'(out_valid8), 1);
    chk("done_acc", int'(acc8), 8'hFC);
    chk("done_sticky", int'(sticky8), 0);
    in_valid = 1'b1;
    q_in = 4'd5;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_in_ready", int'(in_ready8), 0);
      chk("hold_acc", int'(acc8), 8'hFC);
    end
    in_valid = 1'b0;
    take();
    chk("after_xfer_valid", int'(out_valid8), 0);
    chk("after_xfer_acc", int'(acc8), 0);
    $display("batch 1 transferred");

    // ovf_in on the 2nd sample sets sticky
    feed(3, 0); feed(-2, 1); feed(-7, 0); feed(2, 0);
    chk("ovf_sticky", int'(sticky8), 1);
    take();
    chk("ovf_sticky_clr", int'(sticky8), 0);
    $display("batch 2 transferred");

    // Wrap in the 5-bit accumulator
    feed(7, 0); feed(7, 0); feed(7, 0); feed(7, 0);
    chk("wrap_acc5", int'(acc5), 5'b11100);
    chk("wrap_stk5", int'(sticky5), 1);
    chk("wrap_acc8", int'(acc8), 28);
    chk("wrap_stk8", int'(sticky8), 0);
    take();
    $display("batch 3 transferred");

    // clear coincident with the 3rd accept
    feed(1, 0); feed(2, 0);
    clear = 1'b1;
    feed(4, 0);
    clear = 1'b0;
    chk("clr_cnt", int'(cnt8), 0);
    chk("clr_acc", int'(acc8), 0);
    feed(1, 0); feed(1, 0); feed(1, 0); feed(-4, 0);
    chk("clr_full_valid", int'(out_valid8), 1);
    chk("clr_full_acc", int'($signed(acc8)), -1);
    take();
    $display("batch 4 transferred");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      q_in      = 4'($urandom);
      ovf_in    = ($urandom % 8) == 0;
      clear     = ($urandom % 40) == 0;
      out_ready = ($urandom % 2) == 1;
      cyc();
    end
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("queue_drained", exp_acc8.size(), 0);
    $display("%0d batches transferred", n_xfer);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
